pixart_i2c_target: RTL and testbench

- Synthesizable I2C target (responder) that emulates the PixArt IR camera at the far end of the camera's I2C master.
- Used in simulation and as a loopback/bring-up target on a spare pin pair, so the camera master and the x/y tracking path can be exercised without the sensor.
- Accepts the configuration register writes the master issues.
- Returns a 16-byte blob report; blob 1 carries the x/y/size presented on its inputs.

---
 rtl/pixart_pkg.sv | 54 +++++
 rtl/i2c_line_sync.sv | 51 +++++
 rtl/pixart_i2c_target.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_pixart_i2c_target.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixart_pkg.sv
// Shared definitions for the PixArt IR camera I2C target emulation.
// Holds the default bus address and report register, the target FSM state
// encoding, the blob snapshot record and the report byte formatter.
package pixart_pkg;

    localparam logic [6:0]  PIXART_ADDR       = 7'h58;
    localparam logic [7:0]  PIXART_REPORT_REG = 8'h36;
    localparam int unsigned PIXART_REPORT_LEN = 16;

    // Byte offsets of blob 1 inside the extended-format report.
    localparam logic [7:0] BLOB1_XL = 8'd1;
    localparam logic [7:0] BLOB1_YL = 8'd2;
    localparam logic [7:0] BLOB1_HI = 8'd3;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StReg,
        StAckReg,
        StWdata,
        StAckWdata,
        StRdata,
        StRack,
        StWaitStop
    } tgt_state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] size;
        logic       valid;
    } blob_snap_t;

    // Report byte at index idx: byte 0 is a zero header, bytes 1..3 carry
    // blob 1 (or 0xFF when absent), everything else reads as an absent blob.
    function automatic logic [7:0] report_byte(input logic [7:0] idx, input blob_snap_t b);
        logic [7:0] r;
        r = 8'hFF;
        if (idx == 8'd0) begin
            r = 8'h00;
        end else if (b.valid) begin
            if (idx == BLOB1_XL) begin
                r = b.x[7:0];
            end else if (idx == BLOB1_YL) begin
                r = b.y[7:0];
            end else if (idx == BLOB1_HI) begin
                r = {b.y[9:8], b.x[9:8], b.size};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// I2C line conditioning for the PixArt target.
// Two-flop synchronisers on SCL/SDA followed by one history flop, giving
// single-cycle SCL edge strobes and START/STOP detection.
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   scl_in, sda_in    raw pad inputs
//   scl_rise/fall     one-cycle strobes on synchronised SCL edges
//   start_det         SDA fell while SCL high
//   stop_det          SDA rose while SCL high
//   sda_s             synchronised SDA
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // Bit [1] is the synchronised value, bit [2] its one-cycle history.
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    // Reset to the idle-bus level so no edge is reported coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    always_comb begin
        scl_rise  = scl_q[1] & ~scl_q[2];
        scl_fall  = ~scl_q[1] & scl_q[2];
        start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
        stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
        sda_s     = sda_q[1];
    end

endmodule

// File: rtl/pixart_i2c_target.sv
// I2C target emulating the PixArt IR camera for loopback and simulation.
// Accepts config register writes (strobed out on cfg_we/cfg_addr/cfg_data and
// kept in a local config file) and serves a 16-byte blob report from the
// report register, with blob 1 taken from the blob_* inputs.
// Ports:
//   clk, reset                  system clock (>= 8x SCL), async active-low reset
//   scl_in, sda_in              raw I2C pad inputs
//   sda_out_en                  1 = pull SDA low
//   blob_x/y/size/valid         blob 1 position, size and presence
//   cfg_we, cfg_addr, cfg_data  one-cycle config write strobe with pointer/data
//   busy                        high from address match until STOP
module pixart_i2c_target
    import pixart_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = PIXART_ADDR,
    parameter logic [7:0]  REPORT_REG = PIXART_REPORT_REG,
    parameter int unsigned REPORT_LEN = PIXART_REPORT_LEN,
    parameter int unsigned CFG_DEPTH  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out_en,
    input  logic [9:0] blob_x,
    input  logic [9:0] blob_y,
    input  logic [3:0] blob_size,
    input  logic       blob_valid,
    output logic       cfg_we,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       busy
);

    localparam int unsigned CfgAw    = $clog2(CFG_DEPTH);
    localparam logic [8:0]  CfgLimit = 9'(CFG_DEPTH);
    localparam logic [7:0]  IdxLast  = 8'(REPORT_LEN - 1);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    tgt_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] idx_q, idx_d;
    logic       rpt_q, rpt_d;
    logic       mack_q, mack_d;
    blob_snap_t snap_q, snap_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       cfg_we_q, cfg_we_d;
    logic [7:0] cfg_addr_q, cfg_addr_d;
    logic [7:0] cfg_data_q, cfg_data_d;
    logic [7:0] cfg_q [CFG_DEPTH];
    logic [7:0] cfg_d [CFG_DEPTH];

    logic [7:0]       rx_byte;
    logic             ptr_in_cfg;
    logic [CfgAw-1:0] ptr_idx;
    logic [7:0]       src_byte;

    always_comb begin
        rx_byte    = {shift_q[6:0], sda_s};
        ptr_in_cfg = ({1'b0, ptr_q} < CfgLimit);
        ptr_idx    = ptr_q[CfgAw-1:0];
        // Report mode is latched at the read address phase so the pointer can
        // advance per byte without leaving the report.
        if (rpt_q) begin
            src_byte = report_byte(idx_q, snap_q);
        end else if (ptr_in_cfg) begin
            src_byte = cfg_q[ptr_idx];
        end else begin
            src_byte = 8'h00;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        rpt_d      = rpt_q;
        mack_d     = mack_q;
        snap_d     = snap_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        cfg_we_d   = 1'b0;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        cfg_d      = cfg_q;

        // Bus conditions win over any bit activity in the same cycle.
        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end

                StAddr: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = StAckAddr;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            if (shift_q[0]) begin
                                snap_d = {blob_x, blob_y, blob_size, blob_valid};
                                idx_d  = 8'd0;
                                rpt_d  = (ptr_q == REPORT_REG);
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end

                StAckAddr: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        // shift_q still holds the address byte; bit 0 is R/W.
                        if (shift_q[0]) begin
                            state_d  = StRdata;
                            sda_oe_d = ~src_byte[7];
                            tx_d     = {src_byte[6:0], 1'b0};
                        end else begin
                            state_d  = StReg;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                StReg: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ptr_d    = shift_q;
                        sda_oe_d = 1'b1;
                        state_d  = StAckReg;
                    end
                end

                StAckReg, StAckWdata: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StWdata;
                    end
                end

                StWdata: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && ptr_in_cfg) begin
                            cfg_d[ptr_idx] = rx_byte;
                            cfg_we_d       = 1'b1;
                            cfg_addr_d     = ptr_q;
                            cfg_data_d     = rx_byte;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // Out-of-range bytes are still acknowledged.
                        sda_oe_d = 1'b1;
                        ptr_d    = ptr_q + 8'd1;
                        state_d  = StAckWdata;
                    end
                end

                StRdata: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            mack_d    = 1'b0;
                            state_d   = StRack;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end

                StRack: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            // Advance now so src_byte is ready at the next fall.
                            mack_d = 1'b1;
                            ptr_d  = ptr_q + 8'd1;
                            idx_d  = (idx_q == IdxLast) ? 8'd0 : idx_q + 8'd1;
                        end else begin
                            state_d  = StWaitStop;
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StRdata;
                        sda_oe_d  = ~src_byte[7];
                        tx_d      = {src_byte[6:0], 1'b0};
                    end
                end

                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 8'h00;
            idx_q      <= 8'h00;
            rpt_q      <= 1'b0;
            mack_q     <= 1'b0;
            snap_q     <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_addr_q <= 8'h00;
            cfg_data_q <= 8'h00;
            for (int unsigned i = 0; i < CFG_DEPTH; i++) begin
                cfg_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            rpt_q      <= rpt_d;
            mack_q     <= mack_d;
            snap_q     <= snap_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            cfg_we_q   <= cfg_we_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            cfg_q      <= cfg_d;
        end
    end

    always_comb begin
        sda_out_en = sda_oe_q;
        cfg_we     = cfg_we_q;
        cfg_addr   = cfg_addr_q;
        cfg_data   = cfg_data_q;
        busy       = busy_q;
    end

endmodule

// File: tb/tb_pixart_i2c_target.sv
// Directed self-checking bench for pixart_i2c_target: a bit-banged I2C
// master drives the bus and each task checks one scenario.
module tb_pixart_i2c_target;

    localparam int Q = 8;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_out_en;
    logic [9:0] blob_x = 10'h2A5;
    logic [9:0] blob_y = 10'h1C3;
    logic [3:0] blob_size = 4'h7;
    logic       blob_valid = 1'b1;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int         we_cnt = 0;
    int         oe_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] we_addr_log [64];
    logic [7:0] we_data_log [64];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_out_en;

    pixart_i2c_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (m_scl),
        .sda_in     (sda_bus),
        .sda_out_en (sda_out_en),
        .blob_x     (blob_x),
        .blob_y     (blob_y),
        .blob_size  (blob_size),
        .blob_valid (blob_valid),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (cfg_we) begin
            we_addr_log[we_cnt[5:0]] = cfg_addr;
            we_data_log[we_cnt[5:0]] = cfg_data;
            we_cnt++;
        end
        if (sda_out_en) oe_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 2ms)", $time);
        $fatal(1, "watchdog");
    end

    task automatic wq;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wq();
        m_scl = 1'b1; wq(); wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        b = sda_bus; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(nack);
    endtask

    // Pointer write followed by repeated START and read address.
    task automatic begin_read(input logic [7:0] ptr, output logic [2:0] acks);
        i2c_start();
        write_byte(8'hB0, acks[2]);
        write_byte(ptr, acks[1]);
        i2c_start();
        write_byte(8'hB1, acks[0]);
    endtask

    task automatic test_reset;
        tests++; if (sda_out_en !== 1'b0) begin fails++; $display("FAIL reset_sda_out_en: got %b want 0", sda_out_en); end
        tests++; if (cfg_we !== 1'b0) begin fails++; $display("FAIL reset_cfg_we: got %b want 0", cfg_we); end
        tests++; if (cfg_addr !== 8'h00) begin fails++; $display("FAIL reset_cfg_addr: got %h want 00", cfg_addr); end
        tests++; if (cfg_data !== 8'h00) begin fails++; $display("FAIL reset_cfg_data: got %h want 00", cfg_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_addr_mismatch;
        int we0, oe0, b0;
        logic ack;
        we0 = we_cnt; oe0 = oe_cnt; b0 = busy_cnt;
        i2c_start();
        write_byte(8'h42, ack);
        i2c_stop();
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mismatch_ack: got %b want 1", ack); end
        tests++; if (oe_cnt != oe0) begin fails++; $display("FAIL mismatch_sda: got %0d driven clocks want 0", oe_cnt - oe0); end
        tests++; if (busy_cnt != b0) begin fails++; $display("FAIL mismatch_busy: got %0d busy clocks want 0", busy_cnt - b0); end
        tests++; if (we_cnt != we0) begin fails++; $display("FAIL mismatch_cfg_we: got %0d strobes want 0", we_cnt - we0); end
    endtask

    task automatic test_init_write;
        int we0;
        logic [2:0] acks;
        we0 = we_cnt;
        i2c_start();
        write_byte(8'hB0, acks[2]);
        write_byte(8'h30, acks[1]);
        write_byte(8'h01, acks[0]);
        tests++; if (acks !== 3'b000) begin fails++; $display("FAIL init_acks: got %b want 000", acks); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL init_busy_before_stop: got %b want 1", busy); end
        i2c_stop();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_busy_after_stop: got %b want 0", busy); end
        tests++; if (we_cnt - we0 != 1) begin fails++; $display("FAIL init_we_count: got %0d want 1", we_cnt - we0); end
        tests++; if (we_addr_log[we0[5:0]] !== 8'h30 || we_data_log[we0[5:0]] !== 8'h01) begin
            fails++;
            $display("FAIL init_we_payload: got %h=%h want 30=01", we_addr_log[we0[5:0]], we_data_log[we0[5:0]]);
        end
    endtask

    task automatic test_multi_write;
        int we0;
        logic [3:0] acks;
        we0 = we_cnt;
        i2c_start();
        write_byte(8'hB0, acks[3]);
        write_byte(8'h06, acks[2]);
        write_byte(8'h90, acks[1]);
        write_byte(8'hC0, acks[0]);
        i2c_stop();
        tests++; if (acks !== 4'b0000) begin fails++; $display("FAIL multi_acks: got %b want 0000", acks); end
        tests++; if (we_cnt - we0 != 2) begin fails++; $display("FAIL multi_we_count: got %0d want 2", we_cnt - we0); end
        tests++; if (we_addr_log[we0[5:0]] !== 8'h06 || we_data_log[we0[5:0]] !== 8'h90) begin
            fails++;
            $display("FAIL multi_we_first: got %h=%h want 06=90", we_addr_log[we0[5:0]], we_data_log[we0[5:0]]);
        end
        we0++;
        tests++; if (we_addr_log[we0[5:0]] !== 8'h07 || we_data_log[we0[5:0]] !== 8'hC0) begin
            fails++;
            $display("FAIL multi_we_second: got %h=%h want 07=C0", we_addr_log[we0[5:0]], we_data_log[we0[5:0]]);
        end
    endtask

    task automatic test_cfg_read;
        logic [2:0] acks;
        logic [7:0] d;
        begin_read(8'h06, acks);
        tests++; if (acks !== 3'b000) begin fails++; $display("FAIL cfgrd_acks: got %b want 000", acks); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'h90) begin fails++; $display("FAIL cfgrd_byte0: got %h want 90", d); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hC0) begin fails++; $display("FAIL cfgrd_byte1: got %h want C0", d); end
        i2c_stop();
        // Pointer beyond the config file reads as zero.
        begin_read(8'h50, acks);
        read_byte(1'b1, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL cfgrd_out_of_range: got %h want 00", d); end
        i2c_stop();
    endtask

    task automatic test_report_read;
        logic [2:0] acks;
        logic [7:0] d;
        logic [7:0] exp_b [16];
        exp_b = '{8'h00, 8'hA5, 8'hC3, 8'h67, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        blob_x = 10'h2A5; blob_y = 10'h1C3; blob_size = 4'h7; blob_valid = 1'b1;
        begin_read(8'h36, acks);
        tests++; if (acks !== 3'b000) begin fails++; $display("FAIL report_acks: got %b want 000", acks); end
        for (int i = 0; i < 16; i++) begin
            read_byte(i == 15, d);
            tests++; if (d !== exp_b[i]) begin fails++; $display("FAIL report_byte%0d: got %h want %h", i, d, exp_b[i]); end
        end
        tests++; if (sda_out_en !== 1'b0) begin fails++; $display("FAIL report_release_after_nack: got %b want 0", sda_out_en); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL report_busy_wait_stop: got %b want 1", busy); end
        i2c_stop();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL report_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_snapshot_wrap;
        logic [2:0] acks;
        logic [7:0] d;
        logic [7:0] exp_b [18];
        exp_b = '{8'h00, 8'hA5, 8'hC3, 8'h67, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hA5};
        blob_x = 10'h2A5; blob_y = 10'h1C3; blob_size = 4'h7; blob_valid = 1'b1;
        begin_read(8'h36, acks);
        for (int i = 0; i < 18; i++) begin
            if (i == 1) begin
                blob_x = 10'h10F; blob_y = 10'h2E4; blob_size = 4'h2;
            end
            read_byte(i == 17, d);
            tests++; if (d !== exp_b[i]) begin fails++; $display("FAIL snap_byte%0d: got %h want %h", i, d, exp_b[i]); end
        end
        i2c_stop();
        // Absent blob reads as FF in its three bytes.
        blob_valid = 1'b0;
        begin_read(8'h36, acks);
        for (int i = 0; i < 4; i++) begin
            read_byte(i == 3, d);
            tests++; if (d !== ((i == 0) ? 8'h00 : 8'hFF)) begin
                fails++;
                $display("FAIL novalid_byte%0d: got %h want %h", i, d, (i == 0) ? 8'h00 : 8'hFF);
            end
        end
        i2c_stop();
        blob_valid = 1'b1;
    endtask

    task automatic test_mid_reset;
        logic [7:0] a;
        logic [2:0] acks;
        int we0;
        a = 8'hB0;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        tests++; if (sda_out_en !== 1'b1) begin fails++; $display("FAIL midrst_ack_driven: got %b want 1", sda_out_en); end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++; if (sda_out_en !== 1'b0) begin fails++; $display("FAIL midrst_release: got %b want 0", sda_out_en); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_scl = 1'b0; wq();
        i2c_stop();
        we0 = we_cnt;
        i2c_start();
        write_byte(8'hB0, acks[2]);
        write_byte(8'h10, acks[1]);
        write_byte(8'h5A, acks[0]);
        i2c_stop();
        tests++; if (acks !== 3'b000) begin fails++; $display("FAIL midrst_acks: got %b want 000", acks); end
        tests++; if (we_cnt - we0 != 1) begin fails++; $display("FAIL midrst_we_count: got %0d want 1", we_cnt - we0); end
        tests++; if (we_addr_log[we0[5:0]] !== 8'h10 || we_data_log[we0[5:0]] !== 8'h5A) begin
            fails++;
            $display("FAIL midrst_we_payload: got %h=%h want 10=5A", we_addr_log[we0[5:0]], we_data_log[we0[5:0]]);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        test_addr_mismatch();
        test_init_write();
        test_multi_write();
        test_cfg_read();
        test_report_read();
        test_snapshot_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
